// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, and hands words to decode
// through a valid/ready IF/ID register. A zero word means an unmapped fetch and halts the stage.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | fetching sequentially, one word per cycle when the slot is free
// HALT  | an unmapped (all-zero) word was fetched; wait for a redirect
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0001_3880,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        address,
  input  logic [31:0]        instruction,
  input  logic               id_ready,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instruction,
  output logic [31:0]        if_id_pc,
  output logic               misalign_err,
  output logic               fetch_halted,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          ifpc_q, ifpc_d;
  logic                 misalign_q, misalign_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic advance;
  logic xfer;

  assign advance = !valid_q || id_ready;
  assign xfer    = valid_q && id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      ifpc_q     <= 32'h0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    misalign_d = 1'b0;
    count_d    = xfer ? count_q + COUNT_W'(1) : count_q;

    // A redirect squashes the slot even when decode is stalled.
    if (branch_taken) begin
      pc_d       = {branch_target[31:2], 2'b00};
      valid_d    = 1'b0;
      state_d    = S_RUN;
      misalign_d = |branch_target[1:0];
    end else if (state_q == S_HALT) begin
      if (id_ready) valid_d = 1'b0;
    end else if (advance) begin
      if (instruction == 32'h0) begin
        state_d = S_HALT;
        valid_d = 1'b0;
      end else begin
        instr_d = instruction;
        ifpc_d  = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end
    end
  end

  assign address           = pc_q;
  assign if_id_valid       = valid_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc          = ifpc_q;
  assign misalign_err      = misalign_q;
  assign fetch_halted      = (state_q == S_HALT);
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a slot-queue reference model feeds an expectation
// queue that a monitor drains after every clock edge; directed steps follow the test plan.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0001_3880;
  localparam int          COUNT_W  = 16;

  logic               clk;
  logic               rst_n;
  logic [31:0]        address;
  logic [31:0]        instruction;
  logic               id_ready;
  logic               branch_taken;
  logic [31:0]        branch_target;
  logic               if_id_valid;
  logic [31:0]        if_id_instruction;
  logic [31:0]        if_id_pc;
  logic               misalign_err;
  logic               fetch_halted;
  logic [COUNT_W-1:0] fetch_count;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .COUNT_W(COUNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .address           (address),
    .instruction       (instruction),
    .id_ready          (id_ready),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .if_id_valid       (if_id_valid),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .misalign_err      (misalign_err),
    .fetch_halted      (fetch_halted),
    .fetch_count       (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: standard program, two extra mapped windows (one straddling
  // the 32-bit wrap), everything else unmapped and returned as zero.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0001_3880: return 32'h002B_1513;
      32'h0001_3884: return 32'h0195_0533;
      32'h0001_3888: return 32'h0005_3483;
      32'h0001_388C: return 32'h0014_8493;
      32'h0001_3890: return 32'h00A4_84B3;
      32'h0001_3894: return 32'hFE00_06E3;
      default: ;
    endcase
    if (a >= 32'h2000_0000 && a < 32'h2000_0040) return {a[15:0] ^ 16'h5A5A, 16'h0013};
    if (a >= 32'hFFFF_FFF0 || a < 32'h0000_0008) return {a[15:0], 16'h0093};
    return 32'h0;
  endfunction

  always_comb instruction = mem_word(address);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic        mis;
    logic        halt;
    logic [15:0] count;
  } exp_t;

  // Reference model: the IF/ID register is a queue holding at most one entry.
  entry_t      m_slot[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_mis;
  int unsigned m_delivered;
  exp_t        exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot.delete();
    m_pc        = RESET_PC;
    m_halt      = 0;
    m_mis       = 0;
    m_delivered = 0;
    exp_q.delete();
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.addr  = m_pc;
    e.valid = (m_slot.size() > 0);
    e.instr = e.valid ? m_slot[0].instr : 32'h0;
    e.ifpc  = e.valid ? m_slot[0].pc : 32'h0;
    e.mis   = m_mis;
    e.halt  = m_halt;
    e.count = 16'(m_delivered % 65536);
    return e;
  endfunction

  task automatic model_step(input bit rdy, input bit br, input logic [31:0] tgt);
    logic [31:0] w;
    if (m_slot.size() > 0 && rdy) begin
      void'(m_slot.pop_front());
      m_delivered++;
    end
    m_mis = br && (tgt % 4 != 0);
    if (br) begin
      m_slot.delete();
      m_pc   = tgt - (tgt % 4);
      m_halt = 0;
    end else if (!m_halt && m_slot.size() == 0) begin
      w = mem_word(m_pc);
      if (w == 32'h0) m_halt = 1;
      else begin
        m_slot.push_back('{pc: m_pc, instr: w});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, predict, then wait for the next negedge.
  task automatic step(input bit rdy, input bit br, input logic [31:0] tgt);
    id_ready      = rdy;
    branch_taken  = br;
    branch_target = tgt;
    model_step(rdy, br, tgt);
    exp_q.push_back(model_view());
    @(negedge clk);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("address", address, e.addr);
      check("if_id_valid", 32'(if_id_valid), 32'(e.valid));
      if (e.valid) begin
        check("if_id_instruction", if_id_instruction, e.instr);
        check("if_id_pc", if_id_pc, e.ifpc);
      end
      check("misalign_err", 32'(misalign_err), 32'(e.mis));
      check("fetch_halted", 32'(fetch_halted), 32'(e.halt));
      check("fetch_count", 32'(fetch_count), 32'(e.count));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"}, address, RESET_PC);
    check({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    check({tag, "_instr"}, if_id_instruction, 32'h0);
    check({tag, "_ifpc"}, if_id_pc, 32'h0);
    check({tag, "_mis"}, 32'(misalign_err), 32'h0);
    check({tag, "_halt"}, 32'(fetch_halted), 32'h0);
    check({tag, "_count"}, 32'(fetch_count), 32'h0);
  endtask

  // Called at a negedge: assert reset between edges, check it acted without a clock.
  task automatic mid_cycle_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0:       return RESET_PC + 32'($urandom_range(0, 27));
      1:       return 32'h2000_0000 + 32'($urandom_range(0, 16'h47));
      2:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int unsigned c0;
    bit rdy, br;
    rst_n         = 1'b0;
    id_ready      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    check("cycle0_address", address, 32'h0001_3880);

    step(1, 0, 0);
    check("e1_ifpc", if_id_pc, 32'h0001_3880);
    check("e1_instr", if_id_instruction, 32'h002B_1513);
    step(1, 0, 0);
    check("e2_instr", if_id_instruction, 32'h0195_0533);
    check("e2_ifpc", if_id_pc, 32'h0001_3884);
    step(1, 0, 0);
    check("pre_stall_ifpc", if_id_pc, 32'h0001_3888);
    c0 = m_delivered;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("stall_ifpc", if_id_pc, 32'h0001_3888);
      check("stall_address", address, 32'h0001_388C);
      check("stall_count", 32'(fetch_count), c0);
    end
    step(1, 0, 0);
    check("resume_ifpc", if_id_pc, 32'h0001_388C);
    step(1, 0, 0);
    step(1, 0, 0);
    check("last_instr", if_id_instruction, 32'hFE00_06E3);
    step(1, 0, 0);
    check("halt_flag", 32'(fetch_halted), 32'h1);
    check("halt_valid", 32'(if_id_valid), 32'h0);
    check("halt_address", address, 32'h0001_3898);
    check("halt_count", 32'(fetch_count), 32'd6);
    step(1, 0, 0);
    check("halt_hold_address", address, 32'h0001_3898);

    step(1, 1, 32'h0001_3888);
    check("redir_address", address, 32'h0001_3888);
    check("redir_halt", 32'(fetch_halted), 32'h0);
    check("redir_valid", 32'(if_id_valid), 32'h0);
    check("redir_mis", 32'(misalign_err), 32'h0);
    step(1, 0, 0);
    check("redir_instr", if_id_instruction, 32'h0005_3483);

    step(1, 1, 32'h0001_3886);
    check("mis_address", address, 32'h0001_3884);
    check("mis_pulse", 32'(misalign_err), 32'h1);
    step(1, 0, 0);
    check("mis_clear", 32'(misalign_err), 32'h0);
    check("mis_valid", 32'(if_id_valid), 32'h1);

    c0 = m_delivered;
    step(0, 1, 32'h0001_3880);
    check("simul_valid", 32'(if_id_valid), 32'h0);
    check("simul_count", 32'(fetch_count), c0);
    check("simul_address", address, 32'h0001_3880);
    step(0, 0, 0);
    mid_cycle_reset("midrst");

    for (int i = 0; i < 4000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      br  = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      step(rdy, br, rand_target());
      if ($urandom_range(0, 599) == 0) mid_cycle_reset("rnd_rst");
    end

    step(1, 0, 0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's 32-bit address each cycle. It captures the combinationally returned instruction into an IF/ID pipeline register with a valid/ready handshake toward decode. It also handles branch redirects and halts on fetches from unmapped addresses, which the memory returns as all-zero words.

Parameters:
RESET_PC, 32'h0001_3880, PC value loaded on reset (program base address).
COUNT_W, 16, width of the delivered-instruction counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
address  output  32  fetch address to instruction memory; always equals pc
instruction  input  32  instruction word returned combinationally for address
id_ready  input  1  decode stage accepts if_id contents this cycle
branch_taken  input  1  redirect request from execute
branch_target  input  32  redirect target address
if_id_valid  output  1  if_id_instruction/if_id_pc hold a live instruction
if_id_instruction  output  32  registered instruction to decode
if_id_pc  output  32  address the registered instruction came from
misalign_err  output  1  one-cycle pulse: redirect target had nonzero bits [1:0]
fetch_halted  output  1  high while FSM is in HALT
fetch_count  output  COUNT_W  number of instructions delivered (accepted by decode)

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, state=RUN, if_id_valid=0, if_id_instruction=0, if_id_pc=0, misalign_err=0, fetch_halted=0, fetch_count=0. Deassertion takes effect at the next clk edge; the first fetch presents RESET_PC in the first cycle after release.
- address = pc, combinational. Memory read latency is 0, so instruction is sampled in the same cycle.
- advance = !if_id_valid || id_ready (the IF/ID slot is free or is being drained).
- Handshake: a transfer occurs when if_id_valid && id_ready. On a transfer, fetch_count increments by 1 and wraps modulo 2^COUNT_W.
- Per-edge priority, highest first:
  1. branch_taken: pc <= {branch_target[31:2],2'b00}; if_id_valid <= 0 (squash). State goes to RUN, including from HALT. misalign_err <= |branch_target[1:0]. A transfer occurring in the same cycle still counts.
  2. state==HALT: pc holds; if_id_valid <= 0 once the current slot is drained (a valid entry remains visible until accepted).
  3. RUN && advance && instruction==32'b0: treat as an unmapped fetch. State <= HALT, pc holds, if_id_valid <= 0. No instruction is delivered.
  4. RUN && advance && instruction!=0: if_id_instruction <= instruction; if_id_pc <= pc; if_id_valid <= 1; pc <= pc+4.
  5. !advance (decode stall): pc, if_id_* and state all hold.
- misalign_err is 0 on every edge that does not take a redirect.
- fetch_halted = (state==HALT), registered.
- pc+4 wraps modulo 2^32 with no flag.
- Throughput: one instruction per cycle with id_ready held high. There is a one-bubble penalty after each redirect.
- Reset asserted mid-stall or mid-HALT returns all state to the reset values immediately (asynchronous).

Test Plan:
- Reset release with id_ready=1 and the standard program loaded: address=0x00013880 in cycle 0. After edge 1: if_id_pc=0x00013880, if_id_instruction=0x002B1513. After edge 2: if_id_instruction=0x01950533, if_id_pc=0x00013884.
- Stall: drop id_ready for 3 cycles while if_id_pc=0x00013888 is valid. if_id_* and address=0x0001388C hold; fetch_count does not change; resumes in order when id_ready returns.
- Run off the program end: after 0xFE0006E3 at 0x00013894 is delivered, address 0x00013898 returns 0. Next edge: fetch_halted=1, if_id_valid=0, address stays 0x00013898, fetch_count=6.
- Redirect from HALT: branch_taken=1, branch_target=0x00013888. Next edge: address=0x00013888, fetch_halted=0, if_id_valid=0, misalign_err=0. One cycle later if_id_instruction=0x000534 83.
- Misaligned redirect: branch_target=0x00013886. Next edge: pc=0x00013884, misalign_err=1 for exactly one cycle.
- Simultaneous events: branch_taken together with id_ready=0 and a valid slot. The redirect wins, the slot is squashed, and fetch_count is unchanged. Asserting rst_n=0 between clock edges clears all outputs without waiting for clk.
